norm_road_sequencer: RTL and testbench
======================================

# norm_road_sequencer

- Generates the road schedule for normal traffic operation: `current_road_norm` and `norm_op_en`.
- Drives the one-hot normal-operation allow decoder, and is the only source of its inputs.
- Cycles roads 0→1→2→3→0 with a fixed green time per road, separated by an all-red clearance interval.
- Starts and stops under control of the top-level mode controller.

## Interface
Parameters:
- `GREEN_TIME`, default 20: cycles each road holds `norm_op_en`=1. Must be ≥1.
- `CLEAR_TIME`, default 3: all-red cycles between roads, with `norm_op_en`=0. Must be ≥1.
- `CNT_W`, default 8: phase counter width. Must hold max(GREEN_TIME, CLEAR_TIME)−1.

Ports:
- `clk`, in, 1: single clock. All logic is rising-edge.
- `rst`, in, 1: synchronous, active-high reset.
- `norm_mode_en`, in, 1: top controller requests normal operation.
- `car_waiting`, in, 4: per-road vehicle sensor, bit i = road i. Used only with `NORM_SKIP_EMPTY_EN`; ignored otherwise.
- `norm_op_en`, out, 1: allow-decoder enable. High only in GREEN.
- `current_road_norm`, out, 2: road currently or next to be served.
- `road_switch`, out, 1: one-cycle pulse on each CLEAR→GREEN transition.
- `busy`, out, 1: high in GREEN or CLEAR.

## Operation
- Moore FSM with states IDLE, GREEN and CLEAR. All outputs are registered.
- Reset values: state IDLE, counter 0, `norm_op_en`=0, `current_road_norm`=0, `road_switch`=0, `busy`=0.
- IDLE:
  - `norm_mode_en`=1 → GREEN with counter=GREEN_TIME−1. `current_road_norm` is unchanged, so a restart resumes at the stored road.
  - `norm_mode_en`=0 → stay in IDLE.
- GREEN: `norm_op_en`=1. The counter decrements each cycle.
  - Counter==0 → CLEAR with counter=CLEAR_TIME−1.
  - `norm_mode_en`=0 at any cycle → CLEAR immediately (graceful abort). Green is never cut without a clearance.
- CLEAR: `norm_op_en`=0. The counter decrements each cycle. At counter==0:
  - `current_road_norm` ← next road, wrapping 3→0 as 2-bit modulo arithmetic.
  - If `norm_mode_en`=1 → GREEN with counter=GREEN_TIME−1, and `road_switch`=1 for that first GREEN cycle.
  - Else → IDLE, with the advanced road stored.
- `norm_mode_en` dropping during CLEAR has no effect until the CLEAR interval ends.
- `norm_mode_en` reasserting during CLEAR has no effect until the CLEAR interval ends.
- `rst` has priority over all transitions and returns the FSM to the reset values in the following cycle, from any state including mid-GREEN.
- `current_road_norm` changes only on the CLEAR-exit edge, never while `norm_op_en`=1, so the allow decoder never sees a road change while enabled.

## Timing
- `norm_mode_en`=1 sampled in IDLE at edge k → `norm_op_en`=1 from edge k+1.
- GREEN lasts exactly GREEN_TIME cycles. CLEAR lasts exactly CLEAR_TIME cycles.
- Full period is 4·(GREEN_TIME+CLEAR_TIME) cycles per road rotation.
- `road_switch` is high for exactly one cycle, coincident with the first GREEN cycle of the new road. It does not pulse on IDLE→GREEN.
- Abort: `norm_mode_en`=0 sampled in GREEN at edge k → `norm_op_en`=0 from edge k+1, then CLEAR_TIME cycles, then IDLE. `busy`=0 from the first IDLE cycle.

## Configuration
- Macro: `NORM_SKIP_EMPTY_EN`.
- Defined:
  - At CLEAR exit, next road = first road in order cur+1, cur+2, cur+3, cur whose `car_waiting` bit is 1.
  - If `car_waiting`=0000, next road = cur+1.
  - If only the current road is waiting, the road is reselected and `road_switch` still pulses.
  - `car_waiting` is sampled on the CLEAR-exit edge only.
- Undefined: strict round-robin, cur+1. `car_waiting` is unconnected internally.

## Test plan
All scenarios use GREEN_TIME=4, CLEAR_TIME=2.
- Reset then `norm_mode_en`=1 held → road 0 with `norm_op_en`=1 for 4 cycles, 0 for 2 cycles; then road 1, 2, 3, 0. `road_switch` pulses at each new green; period 24 cycles.
- Drop `norm_mode_en` in the 2nd GREEN cycle of road 2 → `norm_op_en`=0 next cycle, 2 CLEAR cycles, then IDLE with road=3. Reassert → road 3 green after 1 cycle, no `road_switch` pulse.
- Assert `rst` in the 3rd GREEN cycle of road 1 → next cycle all outputs at reset values (road=0, `norm_op_en`=0, `busy`=0).
- Toggle `norm_mode_en` 1→0→1 within a CLEAR interval → CLEAR length is still 2 and the next GREEN starts normally.
- With `NORM_SKIP_EMPTY_EN`, road 0 green, `car_waiting`=1000 → next green road 3. With `car_waiting`=0000 → road 1. With only bit 0 set → road 0 again, with a `road_switch` pulse.
- Check throughout: `current_road_norm` never changes while `norm_op_en`=1.

Source files
------------

// File: rtl/norm_road_sequencer.sv
// norm_road_sequencer: normal-operation road schedule for the allow decoder.
// Roads are served in order 0->1->2->3->0. Each road gets GREEN_TIME green
// cycles, then CLEAR_TIME all-red cycles before the next road starts.
// Optional feature macro: NORM_SKIP_EMPTY_EN. When it is defined, the next
// road is the first road with a waiting car; when it is undefined, the order
// is strict round-robin and car_waiting is not used.
//
//  state | meaning
//  IDLE  | not sequencing; stored road kept for the next start
//  GREEN | current road enabled (norm_op_en=1); counting down green time
//  CLEAR | all-red clearance; road advances when the count runs out
module norm_road_sequencer #(
    parameter int GREEN_TIME = 20,
    parameter int CLEAR_TIME = 3,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       norm_mode_en,
    input  logic [3:0] car_waiting,
    output logic       norm_op_en,
    output logic [1:0] current_road_norm,
    output logic       road_switch,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GREEN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] GREEN_LOAD = CNT_W'(GREEN_TIME - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_TIME - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       next_road;

`ifdef NORM_SKIP_EMPTY_EN
    logic [1:0] road_p1;
    logic [1:0] road_p2;
    logic [1:0] road_p3;

    // Pick the first waiting road after the current one; the current road
    // itself is the last candidate, and an empty sensor set advances by one.
    always_comb begin
        road_p1   = current_road_norm + 2'd1;
        road_p2   = current_road_norm + 2'd2;
        road_p3   = current_road_norm + 2'd3;
        next_road = road_p1;
        if (car_waiting[road_p1])
            next_road = road_p1;
        else if (car_waiting[road_p2])
            next_road = road_p2;
        else if (car_waiting[road_p3])
            next_road = road_p3;
        else if (car_waiting[current_road_norm])
            next_road = current_road_norm;
    end
`else
    logic unused_car_waiting;

    // Strict round-robin; sensor input is deliberately not used.
    assign next_road          = current_road_norm + 2'd1;
    assign unused_car_waiting = ^car_waiting;
`endif

    // Sequencer FSM with down-counter timing and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            cnt               <= '0;
            norm_op_en        <= 1'b0;
            current_road_norm <= 2'd0;
            road_switch       <= 1'b0;
            busy              <= 1'b0;
        end else begin
            road_switch <= 1'b0;
            case (state)
                IDLE: begin
                    if (norm_mode_en) begin
                        state      <= GREEN;
                        cnt        <= GREEN_LOAD;
                        norm_op_en <= 1'b1;
                        busy       <= 1'b1;
                    end else begin
                        norm_op_en <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                GREEN: begin
                    // Losing the mode request still goes through clearance.
                    if (!norm_mode_en || cnt == '0) begin
                        state      <= CLEAR;
                        cnt        <= CLEAR_LOAD;
                        norm_op_en <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == '0) begin
                        current_road_norm <= next_road;
                        if (norm_mode_en) begin
                            state       <= GREEN;
                            cnt         <= GREEN_LOAD;
                            norm_op_en  <= 1'b1;
                            road_switch <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    norm_op_en <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_norm_road_sequencer.sv
// Directed testbench for norm_road_sequencer with GREEN_TIME=4, CLEAR_TIME=2.
// Skip-empty scenarios are compiled only when NORM_SKIP_EMPTY_EN is defined.
module tb_norm_road_sequencer;

    logic       clk;
    logic       rst;
    logic       norm_mode_en;
    logic [3:0] car_waiting;
    logic       norm_op_en;
    logic [1:0] current_road_norm;
    logic       road_switch;
    logic       busy;

    int total_cnt;
    int pass_cnt;

    norm_road_sequencer #(
        .GREEN_TIME(4),
        .CLEAR_TIME(2),
        .CNT_W     (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .norm_mode_en     (norm_mode_en),
        .car_waiting      (car_waiting),
        .norm_op_en       (norm_op_en),
        .current_road_norm(current_road_norm),
        .road_switch      (road_switch),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample 1 time unit after the edge. Also checks that
    // the road never moves across an edge where the decoder was enabled.
    task automatic tick();
        logic       prev_op;
        logic [1:0] prev_road;
        logic       prev_rst;
        prev_op   = norm_op_en;
        prev_road = current_road_norm;
        prev_rst  = rst;
        @(posedge clk);
        #1;
        if (prev_op === 1'b1 && prev_rst === 1'b0) begin
            total_cnt++;
            if (current_road_norm !== prev_road)
                $display("FAIL road_stable_while_enabled: got %0d expected %0d at %0t",
                         current_road_norm, prev_road, $time);
            else
                pass_cnt++;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reset and leave the DUT in IDLE, then request normal mode (sampled next edge).
    task automatic start_run();
        rst          = 1'b1;
        norm_mode_en = 1'b0;
        ticks(2);
        rst          = 1'b0;
        norm_mode_en = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        norm_mode_en = 1'b0;
        car_waiting  = 4'b0000;
        ticks(2);
        total_cnt++;
        if ({norm_op_en, current_road_norm, road_switch, busy} !== 5'b0)
            $display("FAIL reset_values: got op=%b road=%0d sw=%b busy=%b expected all 0",
                     norm_op_en, current_road_norm, road_switch, busy);
        else
            pass_cnt++;
        rst = 1'b0;
        ticks(2);
        total_cnt++;
        if ({norm_op_en, busy} !== 2'b00)
            $display("FAIL idle_hold: got op=%b busy=%b expected 0 0", norm_op_en, busy);
        else
            pass_cnt++;
    endtask

    task automatic test_rotation();
        logic       exp_op;
        logic       exp_sw;
        logic [1:0] exp_road;
        start_run();
        // 4 roads x 6 cycles, plus the first cycle of the following period.
        for (int c = 0; c < 25; c++) begin
            exp_road = 2'((c / 6) % 4);
            exp_op   = (c % 6) < 4;
            exp_sw   = (c % 6) == 0 && c != 0;
            total_cnt++;
            if ({norm_op_en, current_road_norm, road_switch, busy} !== {exp_op, exp_road, exp_sw, 1'b1})
                $display("FAIL rotation_c%0d: got op=%b road=%0d sw=%b busy=%b expected op=%b road=%0d sw=%b busy=1",
                         c, norm_op_en, current_road_norm, road_switch, busy, exp_op, exp_road, exp_sw);
            else
                pass_cnt++;
            if (c != 24) tick();
        end
    endtask

    task automatic test_abort();
        start_run();
        ticks(13);
        total_cnt++;
        if ({norm_op_en, current_road_norm} !== {1'b1, 2'd2})
            $display("FAIL abort_pre: got op=%b road=%0d expected op=1 road=2",
                     norm_op_en, current_road_norm);
        else
            pass_cnt++;
        norm_mode_en = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            total_cnt++;
            if ({norm_op_en, current_road_norm, busy} !== {1'b0, 2'd2, 1'b1})
                $display("FAIL abort_clear%0d: got op=%b road=%0d busy=%b expected op=0 road=2 busy=1",
                         c, norm_op_en, current_road_norm, busy);
            else
                pass_cnt++;
        end
        tick();
        total_cnt++;
        if ({norm_op_en, current_road_norm, busy} !== {1'b0, 2'd3, 1'b0})
            $display("FAIL abort_idle: got op=%b road=%0d busy=%b expected op=0 road=3 busy=0",
                     norm_op_en, current_road_norm, busy);
        else
            pass_cnt++;
        norm_mode_en = 1'b1;
        tick();
        total_cnt++;
        if ({norm_op_en, current_road_norm, road_switch, busy} !== {1'b1, 2'd3, 1'b0, 1'b1})
            $display("FAIL abort_resume: got op=%b road=%0d sw=%b busy=%b expected op=1 road=3 sw=0 busy=1",
                     norm_op_en, current_road_norm, road_switch, busy);
        else
            pass_cnt++;
    endtask

    task automatic test_reset_mid_green();
        start_run();
        ticks(8);
        total_cnt++;
        if ({norm_op_en, current_road_norm} !== {1'b1, 2'd1})
            $display("FAIL rstmid_pre: got op=%b road=%0d expected op=1 road=1",
                     norm_op_en, current_road_norm);
        else
            pass_cnt++;
        rst = 1'b1;
        tick();
        total_cnt++;
        if ({norm_op_en, current_road_norm, road_switch, busy} !== 5'b0)
            $display("FAIL rstmid_values: got op=%b road=%0d sw=%b busy=%b expected all 0",
                     norm_op_en, current_road_norm, road_switch, busy);
        else
            pass_cnt++;
        rst = 1'b0;
        tick();
        total_cnt++;
        if ({norm_op_en, current_road_norm, road_switch} !== {1'b1, 2'd0, 1'b0})
            $display("FAIL rstmid_restart: got op=%b road=%0d sw=%b expected op=1 road=0 sw=0",
                     norm_op_en, current_road_norm, road_switch);
        else
            pass_cnt++;
    endtask

    task automatic test_clear_toggle();
        start_run();
        ticks(4);
        total_cnt++;
        if ({norm_op_en, busy} !== 2'b01)
            $display("FAIL toggle_clear0: got op=%b busy=%b expected op=0 busy=1", norm_op_en, busy);
        else
            pass_cnt++;
        norm_mode_en = 1'b0;
        tick();
        total_cnt++;
        if ({norm_op_en, current_road_norm, busy} !== {1'b0, 2'd0, 1'b1})
            $display("FAIL toggle_clear1: got op=%b road=%0d busy=%b expected op=0 road=0 busy=1",
                     norm_op_en, current_road_norm, busy);
        else
            pass_cnt++;
        norm_mode_en = 1'b1;
        tick();
        total_cnt++;
        if ({norm_op_en, current_road_norm, road_switch} !== {1'b1, 2'd1, 1'b1})
            $display("FAIL toggle_next_green: got op=%b road=%0d sw=%b expected op=1 road=1 sw=1",
                     norm_op_en, current_road_norm, road_switch);
        else
            pass_cnt++;
    endtask

`ifdef NORM_SKIP_EMPTY_EN
    task automatic test_skip_empty();
        logic [3:0] cw_vec   [3] = '{4'b1000, 4'b0000, 4'b0001};
        logic [1:0] road_exp [3] = '{2'd3, 2'd1, 2'd0};
        for (int v = 0; v < 3; v++) begin
            car_waiting = cw_vec[v];
            start_run();
            ticks(6);
            total_cnt++;
            if ({norm_op_en, current_road_norm, road_switch} !== {1'b1, road_exp[v], 1'b1})
                $display("FAIL skip_empty_v%0d: got op=%b road=%0d sw=%b expected op=1 road=%0d sw=1",
                         v, norm_op_en, current_road_norm, road_switch, road_exp[v]);
            else
                pass_cnt++;
        end
        car_waiting = 4'b0000;
    endtask
`else
    task automatic test_round_robin_ignores_sensor();
        car_waiting = 4'b1000;
        start_run();
        ticks(6);
        total_cnt++;
        if ({norm_op_en, current_road_norm, road_switch} !== {1'b1, 2'd1, 1'b1})
            $display("FAIL rr_ignore_sensor: got op=%b road=%0d sw=%b expected op=1 road=1 sw=1",
                     norm_op_en, current_road_norm, road_switch);
        else
            pass_cnt++;
        car_waiting = 4'b0000;
    endtask
`endif

    initial begin
        total_cnt    = 0;
        pass_cnt     = 0;
        rst          = 1'b1;
        norm_mode_en = 1'b0;
        car_waiting  = 4'b0000;
        #1;
        test_reset();
        test_rotation();
        test_abort();
        test_reset_mid_green();
        test_clear_toggle();
`ifdef NORM_SKIP_EMPTY_EN
        test_skip_empty();
`else
        test_round_robin_ignores_sensor();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
